// File: rtl/mnv3_stream_pkg.sv
// mnv3_stream_pkg: types and helpers shared by the feature-map stream blocks.
//   stream_tx_state_e : transmitter FSM states
//   CNT_W(n)          : counter width able to index 0..n-1 (at least 1 bit)
//   lane_bits(l, dw)  : packed width of one stream beat
// A package cannot take parameters. Each block therefore declares its own
// lane_vec_t typedef from lane_bits-compatible dimensions.
package mnv3_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_tx_state_e;

    function automatic int CNT_W(input int n);
        return $clog2(n > 1 ? n : 2);
    endfunction

    function automatic int lane_bits(input int lanes, input int dw);
        return lanes * dw;
    endfunction

endpackage

// File: rtl/fmap_raster_counter.sv
// fmap_raster_counter: nested raster position counter (h outer, w, g inner).
//   clk, rst  : clock, synchronous active-high reset
//   clr       : restart at position 0 (start of frame)
//   adv       : step to the next position; wraps to 0 after the final one
//   h, w, g   : current row, column, channel group
//   eol, last : current position is the final group of a row / of the frame
module fmap_raster_counter
    import mnv3_stream_pkg::*;
#(
    parameter int HEIGHT = 7,
    parameter int WIDTH  = 7,
    parameter int GROUPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      adv,
    output logic [CNT_W(HEIGHT)-1:0]  h,
    output logic [CNT_W(WIDTH)-1:0]   w,
    output logic [CNT_W(GROUPS)-1:0]  g,
    output logic                      eol,
    output logic                      last
);

    localparam int HW = CNT_W(HEIGHT);
    localparam int WW = CNT_W(WIDTH);
    localparam int GW = CNT_W(GROUPS);
    localparam logic [HW-1:0] H_LAST = HW'(HEIGHT - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WIDTH - 1);
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    logic [HW-1:0] h_q, h_d;
    logic [WW-1:0] w_q, w_d;
    logic [GW-1:0] g_q, g_d;

    always_comb begin
        h_d = h_q;
        w_d = w_q;
        g_d = g_q;
        if (clr) begin
            h_d = '0;
            w_d = '0;
            g_d = '0;
        end else if (adv) begin
            if (g_q == G_LAST) begin
                g_d = '0;
                if (w_q == W_LAST) begin
                    w_d = '0;
                    h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
                end else begin
                    w_d = w_q + 1'b1;
                end
            end else begin
                g_d = g_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_q <= '0;
            w_q <= '0;
            g_q <= '0;
        end else begin
            h_q <= h_d;
            w_q <= w_d;
            g_q <= g_d;
        end
    end

    assign h    = h_q;
    assign w    = w_q;
    assign g    = g_q;
    assign eol  = (w_q == W_LAST) && (g_q == G_LAST);
    assign last = eol && (h_q == H_LAST);

endmodule

// File: rtl/fmap_stream_tx.sv
// fmap_stream_tx: snapshots a feature-map tensor on start and streams it out
// in raster order (h, w, channel group), LANES elements per beat.
//   clk, rst          : clock, synchronous active-high reset
//   start, fmap_in    : capture request (honoured in IDLE only) and source tensor
//   busy, done        : frame in progress / one-cycle completion pulse
//   m_valid, m_ready  : stream handshake
//   m_data            : lane i = channel g*LANES+i of the current pixel
//   m_eol, m_last     : last group of a row / last beat of the frame
//
// state  | meaning
// IDLE   | waiting for start, outputs quiet
// STREAM | presenting beats from the snapshot, advancing on handshake
// DONE   | one-cycle done pulse, then back to IDLE
module fmap_stream_tx
    import mnv3_stream_pkg::*;
#(
    parameter int HEIGHT     = 7,
    parameter int WIDTH      = 7,
    parameter int CHANNELS   = 16,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                                                       clk,
    input  logic                                                       rst,
    input  logic                                                       start,
    input  logic [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1][DATA_WIDTH-1:0] fmap_in,
    output logic                                                       busy,
    output logic                                                       done,
    output logic                                                       m_valid,
    input  logic                                                       m_ready,
    output logic [0:LANES-1][DATA_WIDTH-1:0]                           m_data,
    output logic                                                       m_eol,
    output logic                                                       m_last
);

    localparam int GROUPS = CHANNELS / LANES;
    localparam int CW     = CNT_W(CHANNELS);

    typedef logic [0:LANES-1][DATA_WIDTH-1:0] lane_vec_t;

    if (CHANNELS % LANES != 0) begin : g_bad_lanes
        $error("fmap_stream_tx: CHANNELS must be a multiple of LANES");
    end

    stream_tx_state_e state_q;
    logic             busy_q;
    logic             done_q;
    logic [0:HEIGHT-1][0:WIDTH-1][0:CHANNELS-1][DATA_WIDTH-1:0] snap_q;

    logic [CNT_W(HEIGHT)-1:0] h_idx;
    logic [CNT_W(WIDTH)-1:0]  w_idx;
    logic [CNT_W(GROUPS)-1:0] g_idx;
    logic                     pos_eol;
    logic                     pos_last;
    logic                     streaming;
    logic                     hs;
    logic                     cnt_clr;

    assign streaming = (state_q == STREAM);
    assign hs        = streaming && m_ready;
    assign cnt_clr   = (state_q == IDLE) && start;

    fmap_raster_counter #(
        .HEIGHT (HEIGHT),
        .WIDTH  (WIDTH),
        .GROUPS (GROUPS)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .adv  (hs),
        .h    (h_idx),
        .w    (w_idx),
        .g    (g_idx),
        .eol  (pos_eol),
        .last (pos_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        snap_q  <= fmap_in;
                        busy_q  <= 1'b1;
                        state_q <= STREAM;
                    end
                end
                STREAM: begin
                    if (hs && pos_last) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // The snapshot is never reset, so the lane mux is forced to zero outside
    // STREAM to keep m_data clean after reset and between frames.
    lane_vec_t        lanes_sel;
    logic [CW-1:0]    ch_idx;

    always_comb begin
        lanes_sel = '0;
        ch_idx    = '0;
        if (streaming) begin
            for (int i = 0; i < LANES; i++) begin
                ch_idx       = CW'(int'(g_idx) * LANES + i);
                lanes_sel[i] = snap_q[h_idx][w_idx][ch_idx];
            end
        end
    end

    assign m_data  = lanes_sel;
    assign m_valid = streaming;
    assign m_eol   = streaming && pos_eol;
    assign m_last  = streaming && pos_last;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
